branch_cmp_seq: RTL
===================

Name: branch_cmp_seq

Overview:
- Multi-cycle, parametrised branch comparator for the execute stage.
- Compares two N-bit operands one CHUNK-bit slice per cycle, starting at the most-significant slice.
- Produces less/equal flags plus a resolved branch-taken bit for the six RISC-V branch funct3 codes.
- Uses a start/busy/valid handshake so wide datapaths can trade latency for a narrow compare slice.

Parameters:
- N, 32: operand width in bits.
- CHUNK, 8: slice width compared per cycle; N mod CHUNK must be 0; NCH = N/CHUNK.
- EARLY_EXIT, 1: 1 = finish at the first differing slice; 0 = always scan all NCH slices, giving constant latency.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request a compare; accepted only while busy_o=0.
- br_op_i  in  3  funct3 code: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 are invalid.
- rs1_d_i  in  N  operand A, sampled on the accepting edge.
- rs2_d_i  in  N  operand B, sampled on the accepting edge.
- busy_o  out  1  high while in SCAN.
- valid_o  out  1  one-cycle pulse when the result is ready.
- br_less_o  out  1  A<B (signed when op[1]=0, unsigned when op[1]=1); held until the next result.
- br_equal_o  out  1  A==B; held until the next result.
- br_taken_o  out  1  branch decision for the latched op; held until the next result.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; busy_o, valid_o, br_less_o, br_equal_o, br_taken_o all 0.
  - Operand, op and index registers are cleared.
  - Reset during SCAN aborts the compare; no valid_o pulse follows.
- States: IDLE, SCAN, DONE.
- Accept:
  - When state is IDLE or DONE and start_i=1 at an edge, latch A, B and op.
  - Set idx=NCH-1 and the diff-found flag to 0; go to SCAN.
  - start_i during SCAN is ignored; nothing is queued.
- Signed handling:
  - When op[1]=0 (BEQ/BNE/BLT/BGE), invert bit N-1 of both operands at latch time.
  - All slice compares are then unsigned.
- SCAN, one slice per cycle (slice idx = bits [idx*CHUNK+CHUNK-1 : idx*CHUNK]):
  - First differing slice: record less = (sliceA < sliceB); set the diff-found flag.
  - Later slices never overwrite the recorded result.
  - EARLY_EXIT=1: go to DONE on the first differing slice, or after idx=0 with no difference.
  - EARLY_EXIT=0: go to DONE only after idx=0.
  - Otherwise decrement idx.
- DONE (lasts exactly one cycle):
  - valid_o=1, busy_o=0.
  - br_equal_o = no difference found; br_less_o = recorded less (0 when equal).
  - br_taken_o: BEQ=eq, BNE=~eq, BLT/BLTU=less, BGE/BGEU=~less; 010/011 give 0.
  - Next state is SCAN if start_i=1 (back-to-back), else IDLE.
- Outputs:
  - The three result outputs update only on entry to DONE; they are stable in IDLE and during the next SCAN.
  - valid_o is never high in IDLE or SCAN.
- Latency:
  - Cycles from the accepting edge to the valid_o cycle = number of slices scanned: 1..NCH with EARLY_EXIT=1, always NCH with EARLY_EXIT=0.
  - Throughput with back-to-back starts is one result per (latency+1) cycles.
- Degenerate case CHUNK=N: NCH=1; every compare takes 1 cycle.

Test Plan:
- N=32, CHUNK=8, BEQ, A=B=0x12345678 -> 4 SCAN cycles, then valid_o=1 with equal=1, less=0, taken=1.
- BLT, A=0xFFFFFFFF, B=0x00000001 -> valid_o 1 cycle after start with less=1, taken=1. Same operands with BLTU -> less=0, taken=0, latency 1.
- BGE, A=0x80000000, B=0x7FFFFFFF -> less=1, taken=0. BNE, A=0x000000FF, B=0x000000FE -> latency 4, equal=0, taken=1.
- EARLY_EXIT=0, BLTU, A=0x01000000, B=0x02000000 -> latency 4; less=1 from the MS slice is kept although the lower slices are equal.
- Handshake:
  - start_i held high during SCAN -> ignored; operands changed mid-scan do not affect the result.
  - start_i=1 in the DONE cycle -> new compare accepted immediately; valid_o pulses exactly once per compare.
- Reset:
  - rst_i asserted asynchronously mid-SCAN -> outputs 0 immediately, state IDLE, no valid_o.
  - After release, BEQ 0/0 -> taken=1.
  - Invalid op 010 with A=B -> equal=1, taken=0.

Source files
------------

// File: rtl/branch_cmp_seq.sv
// Sequential branch comparator: walks the operands one CHUNK-bit slice per cycle from the
// MS slice, then resolves less/equal and the branch decision for the latched funct3.
module branch_cmp_seq #(
  parameter int N          = 32,
  parameter int CHUNK      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [2:0]   br_op_i,
  input  logic [N-1:0] rs1_d_i,
  input  logic [N-1:0] rs2_d_i,
  output logic         busy_o,
  output logic         valid_o,
  output logic         br_less_o,
  output logic         br_equal_o,
  output logic         br_taken_o,
  output logic [1:0]   state_o
);

  localparam int NCH = N / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NCH - 1);
  localparam logic [N-1:0]  SIGN_MASK = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            diff_q, diff_d;
  logic            less_q, less_d;
  logic            res_less_q, res_less_d;
  logic            res_eq_q, res_eq_d;
  logic            res_taken_q, res_taken_d;

  logic [N-1:0]     a_sh, b_sh;
  logic [CHUNK-1:0] slice_a, slice_b;
  logic             diff_now, less_now;
  int               base;

  function automatic logic taken_fn(input logic [2:0] op, input logic less, input logic eq);
    case (op)
      3'b000:         taken_fn = eq;
      3'b001:         taken_fn = ~eq;
      3'b100, 3'b110: taken_fn = less;
      3'b101, 3'b111: taken_fn = ~less;
      default:        taken_fn = 1'b0;
    endcase
  endfunction

  // Handshake: start_i is accepted on an edge where busy_o=0 (IDLE or DONE); it is
  // ignored while busy_o=1. valid_o pulses for exactly one cycle per accepted compare.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    idx_d       = idx_q;
    diff_d      = diff_q;
    less_d      = less_q;
    res_less_d  = res_less_q;
    res_eq_d    = res_eq_q;
    res_taken_d = res_taken_q;

    base     = int'(idx_q) * CHUNK;
    a_sh     = a_q >> base;
    b_sh     = b_q >> base;
    slice_a  = a_sh[CHUNK-1:0];
    slice_b  = b_sh[CHUNK-1:0];
    // The first differing slice decides; later slices cannot overwrite it.
    diff_now = diff_q | (slice_a != slice_b);
    less_now = diff_q ? less_q : (slice_a < slice_b);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          // Flipping the sign bits lets signed ordering use the unsigned slice compare.
          a_d     = rs1_d_i ^ (br_op_i[1] ? '0 : SIGN_MASK);
          b_d     = rs2_d_i ^ (br_op_i[1] ? '0 : SIGN_MASK);
          op_d    = br_op_i;
          idx_d   = LAST_IDX;
          diff_d  = 1'b0;
          less_d  = 1'b0;
          state_d = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        diff_d = diff_now;
        less_d = less_now;
        if ((idx_q == '0) || (EARLY_EXIT && diff_now)) begin
          state_d     = S_DONE;
          res_eq_d    = ~diff_now;
          res_less_d  = less_now;
          res_taken_d = taken_fn(op_q, less_now, ~diff_now);
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      idx_q       <= '0;
      diff_q      <= 1'b0;
      less_q      <= 1'b0;
      res_less_q  <= 1'b0;
      res_eq_q    <= 1'b0;
      res_taken_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      diff_q      <= diff_d;
      less_q      <= less_d;
      res_less_q  <= res_less_d;
      res_eq_q    <= res_eq_d;
      res_taken_q <= res_taken_d;
    end
  end

  assign busy_o     = (state_q == S_SCAN);
  assign valid_o    = (state_q == S_DONE);
  assign br_less_o  = res_less_q;
  assign br_equal_o = res_eq_q;
  assign br_taken_o = res_taken_q;
  assign state_o    = state_q;

endmodule
